// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD types, FSM states and digit helpers
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  function automatic bcd_digit_t nines_comp(bcd_digit_t d);
    return BCD_MAX - d;
  endfunction
endpackage

// File: rtl/bcd_serial_addsub_if.sv
// bcd_serial_addsub_if: start/busy/done request bus of the serial BCD adder/subtractor
interface bcd_serial_addsub_if #(parameter int DIGITS = 4) ();
  logic start, sub, Cin, busy, done, c, err;
  logic [4*DIGITS-1:0] A, B, S;
  modport master(output start, sub, A, B, Cin, input busy, done, S, c, err);
  modport slave(input start, sub, A, B, Cin, output busy, done, S, c, err);
endinterface

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: one-digit BCD add with decimal carry
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co
);
  logic [4:0] t;
  assign t = 5'(a) + 5'(b) + 5'(ci);
  assign co = t > 5'd9;
  assign s = co ? 4'(t - 5'd10) : t[3:0];
endmodule

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial BCD add / ten's-complement subtract, LS digit first
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic rst,
  bcd_serial_addsub_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state;
  logic [W-1:0] a_sr, b_sr, s_sr, b_in, s_shift;
  logic [IW-1:0] idx;
  logic carry, sub_r, bad, co;
  bcd_digit_t sum;
  always_comb begin
    b_in = '0;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      b_in[4*i+:4] = bus.sub ? nines_comp(bus.B[4*i+:4]) : bus.B[4*i+:4];
      bad = bad | (bus.A[4*i+:4] > BCD_MAX) | (bus.B[4*i+:4] > BCD_MAX);
    end
  end
  bcd_digit_adder u_add (.a(a_sr[3:0]), .b(b_sr[3:0]), .ci(carry), .s(sum), .co(co));
  // new digit enters at the top so digit 0 ends up in S[3:0]
  assign s_shift = W'({sum, s_sr} >> 4);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.S <= '0;
      bus.c <= 1'b0;
      bus.err <= 1'b0;
      idx <= '0;
      a_sr <= '0;
      b_sr <= '0;
      s_sr <= '0;
      carry <= 1'b0;
      sub_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_sr <= bus.A;
          b_sr <= b_in;
          sub_r <= bus.sub;
          carry <= bus.sub ^ bus.Cin;
          idx <= '0;
          s_sr <= '0;
          bus.S <= '0;
          bus.c <= 1'b0;
          bus.err <= bad;
          bus.busy <= 1'b1;
          state <= bad ? DONE : RUN;
        end
        RUN: begin
          a_sr <= a_sr >> 4;
          b_sr <= b_sr >> 4;
          s_sr <= s_shift;
          carry <= co;
          idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
          if (idx == IW'(DIGITS - 1)) begin
            state <= DONE;
            bus.done <= 1'b1;
            bus.S <= s_shift;
            bus.c <= sub_r ^ co;
          end
        end
        // error path enters with done low, so the pulse lands one edge later
        DONE: begin
          bus.done <= ~bus.done;
          if (bus.done) begin
            state <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
